// File: rtl/pbc_pkg.sv
// pbc_pkg: shared FSM state type and parity helper for the serial parity checker.
package pbc_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PAR} state_e;
  function automatic logic parity_of(input logic [63:0] data, input logic odd);
    return ^data ^ odd;
  endfunction
endpackage

// File: rtl/pbc_err_cnt.sv
// pbc_err_cnt: saturating event counter with synchronous clear taking priority over increment.
module pbc_err_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/pbc_serial.sv
// pbc_serial: bit-serial frame receiver (DATA_W bits MSB first plus a parity bit)
// that reports each word with its parity error and counts errors.
module pbc_serial
  import pbc_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ODD    = 0,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_start,
  input  logic              in_bit,
  input  logic              err_clr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_err,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int IW = $clog2(DATA_W + 1);
  state_e            st_q, st_d;
  logic [DATA_W-1:0] sh_q, sh_d, dat_q, dat_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              perr_q, perr_d, done_q, done_d;
  logic              start, last, fin, perr_now;
  assign start    = in_valid & in_start;
  assign last     = idx_q == IW'(DATA_W - 1);
  assign fin      = in_valid & ~in_start & (st_q == PAR);
  // the shift register holds every data bit, so its XOR is the running parity
  assign perr_now = in_bit != parity_of(64'(sh_q), ODD != 0);
  always_comb begin
    st_d   = st_q;
    sh_d   = sh_q;
    idx_d  = idx_q;
    dat_d  = dat_q;
    perr_d = perr_q;
    done_d = 1'b0;
    if (start) begin
      st_d  = DATA;
      sh_d  = DATA_W'(in_bit);
      idx_d = IW'(1);
    end else if (in_valid && st_q == DATA) begin
      sh_d  = {sh_q[DATA_W-2:0], in_bit};
      idx_d = idx_q + IW'(1);
      st_d  = last ? PAR : DATA;
    end else if (fin) begin
      dat_d  = sh_q;
      perr_d = perr_now;
      done_d = 1'b1;
      st_d   = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st_q   <= IDLE;
      sh_q   <= '0;
      idx_q  <= '0;
      dat_q  <= '0;
      perr_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      sh_q   <= sh_d;
      idx_q  <= idx_d;
      dat_q  <= dat_d;
      perr_q <= perr_d;
      done_q <= done_d;
    end
  pbc_err_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fin & perr_now),
    .clr   (err_clr),
    .cnt   (err_cnt)
  );
  assign busy       = st_q != IDLE;
  assign done       = done_q;
  assign data_out   = dat_q;
  assign parity_err = perr_q;
endmodule
